// File: rtl/rx_fifo_if.sv
// Bundle of the receiver-side capture signals and the CPU read port of the
// receive FIFO.
//   slave  : the FIFO unit (consumes rx_data/rx_rs/rd_en/clr_overrun)
//   master : the environment (receiver + CPU) driving the FIFO unit
// Signals: rx_data, rx_rs, rx_over_read, rd_en, dout, empty, full, count,
//          overrun, clr_overrun, irq.
interface rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic [7:0]          rx_data;
  logic                rx_rs;
  logic                rx_over_read;
  logic                rd_en;
  logic [7:0]          dout;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                clr_overrun;
  logic                irq;

  modport slave (
    input  rx_data, rx_rs, rd_en, clr_overrun,
    output rx_over_read, dout, empty, full, count, overrun, irq
  );

  modport master (
    output rx_data, rx_rs, rd_en, clr_overrun,
    input  rx_over_read, dout, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/rx_fifo_unit.sv
// Receive buffer behind the MiniUart receiver. Synchronizes the receiver's
// byte-available flag, captures its byte into a show-ahead FIFO and returns a
// one-cycle read-over pulse that clears the flag.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : rx_fifo_if.slave (receiver capture side + CPU read port + status)
module rx_fifo_unit #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned IRQ_LEVEL  = 1
) (
  input  logic       clk,
  input  logic       rst,
  rx_fifo_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StPush, StAck, StWaitLow} state_e;

  state_e                state_q, state_d;
  logic                  rs_s1, rs_s2;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  pop, push_cycle, push_ok, drop;

  // rx_rs comes from a derived clock domain and is cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
    end else begin
      rs_s1 <= bus.rx_rs;
      rs_s2 <= rs_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (rs_s2) state_d = StPush;
      StPush:    state_d = StAck;
      StAck:     state_d = StWaitLow;
      // Wait for the flag to fall so one byte is never captured twice.
      StWaitLow: if (!rs_s2) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign pop        = bus.rd_en && (count_q != '0);
  assign push_cycle = (state_q == StPush);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign push_ok    = push_cycle && ((count_q != CW'(DEPTH)) || pop);
  assign drop       = push_cycle && !push_ok;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop)                 overrun_d = 1'b1;
    else if (bus.clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rx_over_read = (state_q == StAck);
  assign bus.dout         = mem[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == CW'(DEPTH));
  assign bus.overrun      = overrun_q;
  assign bus.irq          = (count_q >= CW'(IRQ_LEVEL)) || overrun_q;
endmodule
